// File: rtl/nids_pkg.sv
// Shared definitions for the NIDS match-reporting path: default widths,
// the report record layout and the saturating drop-counter helper.
package nids_pkg;

  localparam int OFF_W_DEF     = 16;
  localparam int PKT_W_DEF     = 16;
  localparam int MATCH_LAT_DEF = 2;
  localparam int DROP_W        = 16;

  typedef struct packed {
    logic [PKT_W_DEF-1:0] pkt_id;
    logic [OFF_W_DEF-1:0] offset;
  } rpt_rec_t;

  function automatic logic [DROP_W-1:0] drop_inc(input logic [DROP_W-1:0] v);
    return (v == '1) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/match_fifo.sv
// Generic synchronous first-word-fall-through FIFO. The head is held in a
// register so the outputs keep the last head while the FIFO is empty.
module match_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             do_push, do_pop;
  logic             empty_d;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_pop  = pop & ~empty;
  // A pop frees the slot this cycle, so a push into a full FIFO is legal then.
  assign do_push = push & (~full | do_pop);
  assign rdata   = rdata_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    empty_d = (wr_ptr_d == rd_ptr_d);
    rdata_d = rdata_q;
    // Next head is either the entry being written right now or one already in memory.
    if (!empty_d) begin
      if (do_push && (rd_ptr_d == wr_ptr_q)) rdata_d = wdata;
      else                                   rdata_d = mem_q[rd_ptr_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/match_reporter.sv
// Tags each matcher byte with {packet id, offset}, realigns the tag with the
// matcher's final-state flag and queues one report per match.
module match_reporter
  import nids_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int OFF_W     = OFF_W_DEF,
  parameter int PKT_W     = PKT_W_DEF,
  parameter int MATCH_LAT = MATCH_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              byte_valid,
  input  logic              sop,
  input  logic              if_final,
  output logic              rpt_valid,
  input  logic              rpt_ready,
  output logic [PKT_W-1:0]  rpt_pkt_id,
  output logic [OFF_W-1:0]  rpt_offset,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              overflow
);

  typedef struct packed {
    logic [PKT_W-1:0] pkt_id;
    logic [OFF_W-1:0] offset;
  } rec_t;

  logic [PKT_W-1:0] pkt_q, pkt_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic             seen_q, seen_d;
  logic             started_q, started_d;

  logic [MATCH_LAT-1:0]       vld_pipe_q, vld_pipe_d;
  rec_t [MATCH_LAT-1:0]       rec_pipe_q, rec_pipe_d;

  logic [DROP_W-1:0] drop_q, drop_d;
  logic              ovf_q, ovf_d;

  logic push, pop, full, empty;
  rec_t head;

  // Tag of the current byte is the updated counter value.
  always_comb begin
    pkt_d     = pkt_q;
    off_d     = off_q;
    seen_d    = seen_q;
    started_d = started_q;
    if (byte_valid) begin
      started_d = 1'b1;
      if (sop) begin
        off_d  = '0;
        seen_d = 1'b1;
        if (seen_q) pkt_d = pkt_q + PKT_W'(1);
      end else if (!started_q) begin
        off_d = '0;
      end else if (off_q != '1) begin
        off_d = off_q + OFF_W'(1);
      end
    end
  end

  always_comb begin
    vld_pipe_d           = vld_pipe_q;
    rec_pipe_d           = rec_pipe_q;
    vld_pipe_d[0]        = byte_valid;
    rec_pipe_d[0].pkt_id = pkt_d;
    rec_pipe_d[0].offset = off_d;
    for (int i = 1; i < MATCH_LAT; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      rec_pipe_d[i] = rec_pipe_q[i-1];
    end
  end

  assign push = vld_pipe_q[MATCH_LAT-1] & if_final;
  assign pop  = rpt_valid & rpt_ready;

  always_comb begin
    drop_d = drop_q;
    ovf_d  = ovf_q;
    if (push && full && !pop) begin
      drop_d = drop_inc(drop_q);
      ovf_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_q      <= '0;
      off_q      <= '0;
      seen_q     <= 1'b0;
      started_q  <= 1'b0;
      vld_pipe_q <= '0;
      rec_pipe_q <= '0;
      drop_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      pkt_q      <= pkt_d;
      off_q      <= off_d;
      seen_q     <= seen_d;
      started_q  <= started_d;
      vld_pipe_q <= vld_pipe_d;
      rec_pipe_q <= rec_pipe_d;
      drop_q     <= drop_d;
      ovf_q      <= ovf_d;
    end
  end

  match_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PKT_W + OFF_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (rec_pipe_q[MATCH_LAT-1]),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign rpt_valid  = ~empty;
  assign rpt_pkt_id = head.pkt_id;
  assign rpt_offset = head.offset;
  assign drop_cnt   = drop_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_match_reporter.sv
// Scoreboard bench: two reporters (default and 4-bit offset) share one
// stimulus stream; expected records are queued as matches are driven.
module tb_match_reporter;
  localparam int LAT   = 2;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic byte_valid = 1'b0, sop = 1'b0, if_final = 1'b0, rpt_ready = 1'b0;

  logic        a_valid, b_valid, a_ovf, b_ovf;
  logic [15:0] a_pkt, b_pkt, a_off, a_drop, b_drop;
  logic [3:0]  b_off;

  always #5 clk = ~clk;

  match_reporter #(.DEPTH(DEPTH), .OFF_W(16), .PKT_W(16), .MATCH_LAT(LAT)) dut_a (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .sop(sop), .if_final(if_final),
    .rpt_valid(a_valid), .rpt_ready(rpt_ready), .rpt_pkt_id(a_pkt), .rpt_offset(a_off),
    .drop_cnt(a_drop), .overflow(a_ovf));

  match_reporter #(.DEPTH(DEPTH), .OFF_W(4), .PKT_W(16), .MATCH_LAT(LAT)) dut_b (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .sop(sop), .if_final(if_final),
    .rpt_valid(b_valid), .rpt_ready(rpt_ready), .rpt_pkt_id(b_pkt), .rpt_offset(b_off),
    .drop_cnt(b_drop), .overflow(b_ovf));

  typedef struct {int p; int o;} exp_t;
  exp_t sb[$];

  int n_vec = 0, n_err = 0;
  int exp_drop = 0;
  bit exp_push = 0;
  int exp_p = 0, exp_o = 0;

  // spec-level tagging model
  int m_pkt = 0, m_off = 0, cyc = 0;
  bit m_seen = 0, m_have = 0;
  bit hv[8];
  int hp[8], ho[8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit bv, input bit sp, input bit fin, input bit rdy);
    int slot, old;
    byte_valid = bv; sop = sp; if_final = fin; rpt_ready = rdy;
    if (bv) begin
      if (sp) begin
        if (m_seen) m_pkt++;
        m_seen = 1; m_off = 0;
      end else begin
        m_off = m_have ? m_off + 1 : 0;
      end
      m_have = 1;
    end
    slot = cyc % 8;
    hv[slot] = bv; hp[slot] = m_pkt; ho[slot] = m_off;
    old = (cyc + 8 - LAT) % 8;
    exp_push = fin && hv[old];
    exp_p = hp[old]; exp_o = ho[old];
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1; byte_valid = 0; sop = 0; if_final = 0; rpt_ready = 0;
    exp_push = 0;
    sb.delete();
    exp_drop = 0; m_pkt = 0; m_off = 0; m_seen = 0; m_have = 0;
    for (int i = 0; i < 8; i++) hv[i] = 0;
    @(posedge clk); #1;
    reset = 0;
    chk("rst_valid", a_valid, 0);
    chk("rst_pkt", a_pkt, 0);
    chk("rst_off", a_off, 0);
    chk("rst_drop", a_drop, 0);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_valid_b", b_valid, 0);
  endtask

  // Compare DUT state against the scoreboard midway through every cycle.
  always @(negedge clk) begin
    int  pre;
    bit  hs;
    if (!reset) begin
      pre = sb.size();
      chk("valid_a", a_valid, pre != 0);
      chk("valid_b", b_valid, pre != 0);
      chk("drop_a", a_drop, exp_drop);
      chk("drop_b", b_drop, exp_drop);
      chk("ovf_a", a_ovf, exp_drop != 0);
      chk("ovf_b", b_ovf, exp_drop != 0);
      hs = (pre != 0) && rpt_ready;
      if (pre != 0) begin
        chk("pkt_a", a_pkt, sb[0].p & 32'hFFFF);
        chk("pkt_b", b_pkt, sb[0].p & 32'hFFFF);
        chk("off_a", a_off, (sb[0].o > 65535) ? 65535 : sb[0].o);
        chk("off_b", b_off, (sb[0].o > 15) ? 15 : sb[0].o);
      end
      if (hs) void'(sb.pop_front());
      if (exp_push) begin
        if (pre == DEPTH && !hs) exp_drop = (exp_drop == 65535) ? 65535 : exp_drop + 1;
        else sb.push_back('{exp_p, exp_o});
      end
    end
  end

  task automatic drain();
    for (int k = 0; k < 64 && sb.size() != 0; k++) cycle(0, 0, 0, 1);
    chk("drain_empty", sb.size(), 0);
    cycle(0, 0, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // 1: single match on byte 4 of a 10-byte packet
    for (int i = 0; i <= 9 + LAT; i++) cycle(i < 10, i == 0, i == 4 + LAT, 0);
    chk("t1_held", a_valid, 1);
    drain();
    chk("t1_clear", a_valid, 0);

    // 2: back-to-back packets, stray if_final with no aligned byte
    do_reset();
    for (int i = 0; i <= 6 + LAT; i++)
      cycle(i < 6, i == 0 || i == 3, i == LAT || i == 3 + LAT || i == 6 + LAT, 1);
    drain();

    // 3: 20 matches with consumer stalled -> 16 held, 4 dropped
    do_reset();
    for (int i = 0; i < 20 + LAT; i++) cycle(i < 20, i == 0, i >= LAT, 0);
    cycle(0, 0, 0, 0);
    chk("t3_drop", a_drop, 4);
    chk("t3_ovf", a_ovf, 1);

    // 4: push coinciding with pop while full -> no drop
    cycle(1, 0, 0, 0);
    repeat (LAT - 1) cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 1);
    cycle(0, 0, 0, 0);
    chk("t4_drop", a_drop, 4);
    chk("t4_count", sb.size(), 16);
    drain();
    chk("t4_empty", a_valid, 0);

    // 5: offset saturation on the 4-bit instance
    do_reset();
    for (int i = 0; i <= 19 + LAT; i++) cycle(i < 20, i == 0, i == 19 + LAT, 1);
    drain();

    // 6: reset with records queued and bytes in flight
    do_reset();
    for (int i = 0; i < 7; i++) cycle(1, i == 0, i >= LAT && i < LAT + 5, 0);
    chk("t6_queued", sb.size(), 5);
    do_reset();
    for (int i = 0; i <= 2 + LAT; i++) cycle(i < 3, 0, i == 2 + LAT, 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
